// File: rtl/sdram_pattern_tester_if.sv
// Request/acknowledge bus between the pattern tester and the SDRAM controller request port.
// The tester is the master: it issues strobes, and the controller answers with ack and read data.
interface sdram_pattern_tester_if #(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned DATA_BITS = 16
);
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [1:0]           mem_ds;
    logic                 mem_ack;
    logic [DATA_BITS-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_ds,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_ds,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: writes a pattern across a word window, reads it back and compares,
// reporting pass/fail, error count, completed passes and details of the first mismatch.
module sdram_pattern_tester #(
    parameter int unsigned ADDR_BITS      = 24,
    parameter int unsigned DATA_BITS      = 16,
    parameter int unsigned DEPTH_BITS     = 8,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   loop_en,
    sdram_pattern_tester_if.master mem_bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [15:0]            err_count,
    output logic [15:0]            pass_count,
    output logic [ADDR_BITS-1:0]   first_err_addr,
    output logic [DATA_BITS-1:0]   first_err_exp,
    output logic [DATA_BITS-1:0]   first_err_got
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StPassEnd, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DEPTH_BITS-1:0] idx_q, idx_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [DATA_BITS-1:0]  walk_q, walk_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic                  timeout_q, timeout_d;
    logic                  pass_q, pass_d;
    logic [15:0]           err_q, err_d;
    logic [15:0]           pcnt_q, pcnt_d;
    logic [ADDR_BITS-1:0]  fe_addr_q, fe_addr_d;
    logic [DATA_BITS-1:0]  fe_exp_q, fe_exp_d;
    logic [DATA_BITS-1:0]  fe_got_q, fe_got_d;

    logic [DATA_BITS-1:0]  pattern;
    logic [31:0]           lfsr_next;
    logic [DATA_BITS-1:0]  walk_next;
    logic [ADDR_BITS-1:0]  word_addr;
    logic                  idx_last;
    logic                  in_wr;
    logic                  in_bus;

    // Galois form of x^32+x^22+x^2+x+1, shifting right
    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    assign walk_next = (walk_q << 1) | (walk_q >> (DATA_BITS - 1));
    assign idx_last  = (idx_q == {DEPTH_BITS{1'b1}});
    assign word_addr = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(idx_q);

    always_comb begin
        case (mode_q)
            2'd0:    pattern = DATA_BITS'(idx_q);
            2'd1:    pattern = ~DATA_BITS'(idx_q);
            2'd2:    pattern = walk_q;
            default: pattern = lfsr_q[DATA_BITS-1:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        walk_d    = walk_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        err_d     = err_q;
        pcnt_d    = pcnt_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StWrReq;
                    mode_d    = mode;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    pcnt_d    = '0;
                    fe_addr_d = '0;
                    fe_exp_d  = '0;
                    fe_got_d  = '0;
                end
            end
            StWrReq: begin
                state_d = StWrWait;
                wait_d  = '0;
            end
            StRdReq: begin
                state_d = StRdWait;
                wait_d  = '0;
            end
            StWrWait, StRdWait: begin
                // An ack in the same cycle as the timeout limit still completes the word
                if (mem_bus.mem_ack) begin
                    lfsr_d = lfsr_next;
                    walk_d = walk_next;
                    if (state_q == StRdWait && mem_bus.mem_rdata != pattern) begin
                        if (err_q == '0) begin
                            fe_addr_d = word_addr;
                            fe_exp_d  = pattern;
                            fe_got_d  = mem_bus.mem_rdata;
                        end
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end
                    if (idx_last) begin
                        state_d = (state_q == StWrWait) ? StRdReq : StPassEnd;
                        idx_d   = '0;
                    end else begin
                        state_d = (state_q == StWrWait) ? StWrReq : StRdReq;
                        idx_d   = idx_q + DEPTH_BITS'(1);
                    end
                end else if (wait_q == TW'(TIMEOUT_CYCLES)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            StPassEnd: begin
                pcnt_d = pcnt_q + 16'd1;
                if (loop_en) begin
                    state_d = StWrReq;
                    idx_d   = '0;
                end else begin
                    state_d = StDone;
                    pass_d  = (err_q == '0);
                end
            end
            default: state_d = StIdle;
        endcase

        // Each phase restarts the generators so the read phase regenerates the written words
        if ((state_d == StWrReq || state_d == StRdReq) && idx_d == '0 && state_d != state_q) begin
            lfsr_d = LFSR_SEED;
            walk_d = DATA_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            idx_q     <= '0;
            lfsr_q    <= '0;
            walk_q    <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            pcnt_q    <= '0;
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            lfsr_q    <= lfsr_d;
            walk_q    <= walk_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            pcnt_q    <= pcnt_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    assign in_wr  = (state_q == StWrReq) || (state_q == StWrWait);
    assign in_bus = in_wr || (state_q == StRdReq) || (state_q == StRdWait);

    assign mem_bus.mem_req   = (state_q == StWrReq) || (state_q == StRdReq);
    assign mem_bus.mem_we    = in_wr;
    assign mem_bus.mem_addr  = in_bus ? word_addr : '0;
    assign mem_bus.mem_wdata = in_wr ? pattern : '0;
    assign mem_bus.mem_ds    = 2'b11;

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign pass_count     = pcnt_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a 3-cycle-ack memory model with fault injection, an expected
// request stream built from the pattern rules, and end-of-run status checks.
module tb_sdram_pattern_tester;
    localparam int unsigned AB = 24;
    localparam int unsigned DB = 16;
    localparam int unsigned DEP = 4;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic loop_en = 1'b0;
    logic busy, done, pass, timeout;
    logic [15:0] err_count, pass_count;
    logic [AB-1:0] first_err_addr;
    logic [DB-1:0] first_err_exp, first_err_got;

    sdram_pattern_tester_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    sdram_pattern_tester #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH_BITS(DEP), .BASE_ADDR(0),
        .TIMEOUT_CYCLES(TO), .LFSR_SEED(32'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .loop_en(loop_en),
        .mem_bus(bus), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .pass_count(pass_count), .first_err_addr(first_err_addr),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    logic [15:0] mem [0:15];
    logic [15:0] flip_mask [0:15];
    logic [15:0] stuck0;
    bit          no_ack;

    logic        exp_we   [0:1023];
    logic [23:0] exp_addr [0:1023];
    logic [15:0] exp_data [0:1023];
    int head = 0;
    int tail = 0;

    int pending = 0;
    logic        cur_we;
    logic [23:0] cur_addr;
    logic [15:0] cur_data;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] galois(logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    // Word the spec says is written at index i for a given mode
    function automatic logic [15:0] pat(int m, int i);
        logic [31:0] l;
        l = 32'hACE1;
        for (int k = 0; k < i; k++) l = galois(l);
        case (m)
            0:       return 16'(i);
            1:       return ~16'(i);
            2:       return 16'(1) << i;
            default: return l[15:0];
        endcase
    endfunction

    function automatic logic [15:0] readback(int i, logic [15:0] d);
        return (d ^ flip_mask[i]) & ~stuck0;
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) flip_mask[i] = '0;
        stuck0 = '0;
    endtask

    task automatic push(logic we, int a, logic [15:0] d);
        exp_we[tail] = we;
        exp_addr[tail] = 24'(a);
        exp_data[tail] = d;
        tail++;
    endtask

    task automatic push_pass(int m);
        for (int i = 0; i < 16; i++) push(1'b1, i, pat(m, i));
        for (int i = 0; i < 16; i++) push(1'b0, i, 16'h0);
    endtask

    // One clock: memory model response plus request-stream comparison, all at the falling edge
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            pending = 0;
            bus.mem_ack = 1'b0;
            head = tail;
            return;
        end
        bus.mem_ack = 1'b0;
        if (pending > 0) begin
            pending--;
            if (pending == 0 && !no_ack) begin
                chk("hold_until_ack", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                    {cur_we, cur_addr, cur_data});
                bus.mem_ack = 1'b1;
                if (cur_we) mem[cur_addr[3:0]] = cur_data;
                else bus.mem_rdata = readback(int'(cur_addr[3:0]), mem[cur_addr[3:0]]);
            end
        end
        if (bus.mem_req) begin
            chk("req_expected", 64'(tail > head), 64'd1);
            chk("req_ds", bus.mem_ds, 2'b11);
            if (tail > head) begin
                chk("req_we", bus.mem_we, exp_we[head]);
                chk("req_addr", bus.mem_addr, exp_addr[head]);
                if (exp_we[head]) chk("req_wdata", bus.mem_wdata, exp_data[head]);
                cur_we = exp_we[head];
                cur_addr = exp_addr[head];
                cur_data = exp_we[head] ? exp_data[head] : bus.mem_wdata;
                head++;
            end else begin
                cur_we = bus.mem_we;
                cur_addr = bus.mem_addr;
                cur_data = bus.mem_wdata;
            end
            pending = 3;
        end
    endtask

    task automatic run(int m, int passes, bit inject);
        int cycles;
        bit injected;
        injected = 0;
        mode = 2'(m);
        loop_en = (passes > 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 3000) begin
            if (pass_count >= 16'(passes - 1)) loop_en = 1'b0;
            if (inject && !injected && busy && !bus.mem_we && !bus.mem_req &&
                bus.mem_addr == 24'd8) begin
                start = 1'b1;
                mode = 2'd3;
                injected = 1;
            end
            tick();
            start = 1'b0;
            cycles++;
        end
        chk("done_within_bound", 64'(done), 64'd1);
        if (inject) chk("start_injected", 64'(injected), 64'd1);
    endtask

    task automatic check_end(int m, int passes);
        int errs;
        int fi;
        logic [15:0] fe, fg;
        errs = 0;
        fi = -1;
        fe = '0;
        fg = '0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] p, g;
            p = pat(m, i);
            g = readback(i, p);
            if (g != p) begin
                if (fi < 0) begin
                    fi = i;
                    fe = p;
                    fg = g;
                end
                errs++;
            end
        end
        chk("busy_end", busy, 0);
        chk("done_end", done, 1);
        chk("timeout_end", timeout, 0);
        chk("err_count", err_count, 64'(errs * passes));
        chk("pass_count", pass_count, 64'(passes));
        chk("pass_flag", pass, 64'(errs == 0));
        chk("first_err_addr", first_err_addr, (fi < 0) ? 64'd0 : 64'(fi));
        chk("first_err_exp", first_err_exp, fe);
        chk("first_err_got", first_err_got, fg);
        chk("stream_drained", 64'(tail - head), 64'd0);
    endtask

    initial begin
        int wr_wait_cycles;
        int cyc;
        int reqs;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        no_ack = 0;
        clear_faults();
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_first_err", {first_err_addr, first_err_exp, first_err_got}, 0);
        chk("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_ds", bus.mem_ds, 2'b11);
        reset = 1'b0;
        tick();

        // mode0 on a clean memory
        push_pass(0);
        run(0, 1, 0);
        check_end(0, 1);
        chk("mode0_word5", mem[5], 16'h0005);
        chk("mode0_word15", mem[15], 16'h000F);

        // Stray ack while finished is ignored
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        tick();
        chk("stray_ack_done", done, 1);
        chk("stray_ack_err", err_count, 0);

        // mode3 with bit0 flipped at address 5
        flip_mask[5] = 16'h0001;
        push_pass(3);
        run(3, 1, 0);
        check_end(3, 1);
        chk("lfsr_word0", mem[0], 16'hACE1);
        chk("lfsr_word1", mem[1], 16'h5673);
        chk("mode3_got_lit", first_err_got, pat(3, 5) ^ 16'h0001);
        clear_faults();

        // Controller never acknowledges
        no_ack = 1;
        push(1'b1, 0, pat(0, 0));
        mode = 2'd0;
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_wait_cycles = 0;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            if (busy && bus.mem_we && !bus.mem_req) wr_wait_cycles++;
            cyc++;
        end
        chk("to_wr_wait_cycles", wr_wait_cycles, 21);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);
        chk("to_pass", pass, 0);
        chk("to_stream", 64'(tail - head), 0);
        no_ack = 0;

        // Three looped LFSR passes, identical streams each time
        push_pass(3);
        push_pass(3);
        push_pass(3);
        run(3, 3, 0);
        check_end(3, 3);

        // start during a read wait must not restart the test
        push_pass(1);
        run(1, 1, 1);
        check_end(1, 1);

        // Walking one with bit 15 stuck at zero
        stuck0 = 16'h8000;
        push_pass(2);
        run(2, 1, 0);
        check_end(2, 1);
        chk("walk_word1", mem[1], 16'h0002);
        chk("walk_word15", mem[15], 16'h8000);
        chk("walk_got_lit", first_err_got, 16'h0000);
        clear_faults();

        // Reset during a write wait
        push_pass(0);
        mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(busy && bus.mem_we && !bus.mem_req && bus.mem_addr == 24'd2) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reached_wr_wait", 64'(cyc < 100), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        reqs = 0;
        repeat (40) begin
            tick();
            if (bus.mem_req) reqs++;
        end
        chk("rst_mid_no_req", reqs, 0);
        chk("rst_mid_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
